// File: rtl/dec_conv_sched.sv
// Round-robin scheduler sharing one 4-bit binary-to-decimal converter among four requesters.
// Define DEC_CONV_SCHED_FIXED_PRI_EN for fixed priority (channel 0 highest) instead of round-robin.
module dec_conv_sched (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [3:0]  req,
    input  logic [15:0] val_in,
    output logic [3:0]  gnt,
    output logic [3:0]  ack,
    output logic        busy,
    output logic [3:0]  tens,
    output logic [15:0] ones,
    output logic [3:0]  valid
);

    typedef enum logic [1:0] {IDLE, LOAD, CONV, WB} state_t;

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [3:0]  opd_q, opd_d;
    logic [4:0]  conv_q, conv_d;
    logic [3:0]  ack_q, ack_d;
    logic [3:0]  tens_q, tens_d;
    logic [15:0] ones_q, ones_d;
    logic [3:0]  valid_q, valid_d;

    logic [3:0]  elig;
    logic [1:0]  search_start;
    logic        pick_vld;
    logic [1:0]  pick_idx;

    // Returns {z, ones}: z flags operand > 9, ones is the operand folded back into 0..9.
    function automatic logic [4:0] bin2dec(input logic [3:0] v);
        logic z;
        z = v[3] & (v[2] | v[1]);
        return z ? {1'b1, v - 4'd10} : {1'b0, v};
    endfunction

    // Lowest offset from start wins; returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] e, input logic [1:0] start);
        logic [1:0] idx;
        logic [2:0] r;
        r = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (e[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

`ifdef DEC_CONV_SCHED_FIXED_PRI_EN
    assign search_start = 2'd0;
`else
    assign search_start = ptr_q;
`endif

    // A channel whose ack is still visible is not re-granted in the same IDLE cycle.
    assign elig = req & ~ack_q;
    assign {pick_vld, pick_idx} = rr_pick(elig, search_start);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            opd_q   <= '0;
            conv_q  <= '0;
            ack_q   <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            opd_q   <= opd_d;
            conv_q  <= conv_d;
            ack_q   <= ack_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_vld) state_d = LOAD;
            LOAD:    state_d = CONV;
            CONV:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        opd_d   = opd_q;
        conv_d  = conv_q;
        ack_d   = '0;
        tens_d  = tens_q;
        ones_d  = ones_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gnt_d = 4'b0001 << pick_idx;
                    opd_d = val_in[{pick_idx, 2'b00} +: 4];
`ifdef DEC_CONV_SCHED_FIXED_PRI_EN
                    ptr_d = 2'd0;
`else
                    ptr_d = pick_idx + 2'd1;
`endif
                end
            end
            LOAD: conv_d = bin2dec(opd_q);
            WB: begin
                // Slot write and ack land on the edge that returns to IDLE.
                for (int i = 0; i < 4; i++) begin
                    if (gnt_q[i]) begin
                        tens_d[i]         = conv_q[4];
                        ones_d[4*i +: 4]  = conv_q[3:0];
                        valid_d[i]        = 1'b1;
                    end
                end
                ack_d = gnt_q;
                gnt_d = '0;
            end
            default: ;
        endcase
    end

    assign gnt   = gnt_q;
    assign ack   = ack_q;
    assign busy  = (state_q != IDLE);
    assign tens  = tens_q;
    assign ones  = ones_q;
    assign valid = valid_q;

endmodule
